debug_probe: RTL and testbench

DEBUG_PROBE -- requirements
Module: debug_probe

---
 rtl/debug_probe_pkg.sv | 29 ++
 rtl/debug_probe_if.sv | 36 +++
 rtl/debug_step_gen.sv | 44 ++++
 rtl/debug_probe.sv | 133 +++++++++++++
 tb/tb_debug_probe.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_probe_pkg.sv
// debug_probe shared types: command codes, FSM states, dump range.
// DEBUG_PROBE_TESTSIG_EN extends the dump to the 32 test signals.
package debug_probe_pkg;

  typedef enum logic [1:0] {
    CMD_RUN  = 2'b00,
    CMD_HALT = 2'b01,
    CMD_STEP = 2'b10,
    CMD_DUMP = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    STEP_HI,
    STEP_LO,
    SET_ADDR,
    SETTLE_W,
    EMIT
  } state_e;

`ifdef DEBUG_PROBE_TESTSIG_EN
  localparam int DUMP_LAST = 63;
`else
  localparam int DUMP_LAST = 31;
`endif

  localparam logic [5:0] DUMP_LAST6 = 6'(DUMP_LAST);

endpackage

// File: rtl/debug_probe_if.sv
// debug_probe command and dump-word handshakes.
// master = host side, slave = probe side.
interface debug_probe_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_addr;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output cmd_valid,
    output cmd_op,
    input  cmd_ready,
    input  out_valid,
    output out_ready,
    input  out_addr,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    output cmd_ready,
    output out_valid,
    input  out_ready,
    output out_addr,
    output out_data,
    output out_last
  );

endinterface

// File: rtl/debug_step_gen.sv
// Step pulse generator: STEP_HIGH cycles high, then STEP_HIGH low.
// busy drops combinationally in the final low cycle.
module debug_step_gen #(
  parameter int STEP_HIGH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic step,
  output logic busy,
  output logic hi_done
);

  localparam int CW = $clog2(2 * STEP_HIGH);
  localparam logic [CW-1:0] HI_END = CW'(STEP_HIGH - 1);
  localparam logic [CW-1:0] LO_END = CW'(2 * STEP_HIGH - 1);

  logic          run;
  logic [CW-1:0] cnt;

  assign hi_done = run && (cnt == HI_END);
  assign busy    = run && (cnt != LO_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      run  <= 1'b0;
      cnt  <= '0;
      step <= 1'b0;
    end else if (start) begin
      run  <= 1'b1;
      cnt  <= '0;
      step <= 1'b1;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (hi_done)
        step <= 1'b0;
      if (cnt == LO_END) begin
        run <= 1'b0;
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/debug_probe.sv
// Debug probe: run/halt/step control and register dump of a core.
// Define DEBUG_PROBE_TESTSIG_EN to dump addresses 0..63 instead of 0..31.
module debug_probe
  import debug_probe_pkg::*;
#(
  parameter int STEP_HIGH = 4,
  parameter int SETTLE    = 2
) (
  input  logic          clk,
  input  logic          rst,
  debug_probe_if.slave  bus,
  output logic          debug_en,
  output logic          debug_step,
  output logic [6:0]    debug_addr,
  input  logic [31:0]   debug_data,
  output logic          err
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] WEND = SW'(SETTLE - 1);

  state_e        state;
  logic [5:0]    addr;
  logic [SW-1:0] wcnt;
  logic          accept;
  logic          op_run;
  logic          op_halt;
  logic          op_step;
  logic          op_dump;
  logic          bad_cmd;
  logic          go_step;
  logic          go_dump;
  logic          step_busy;
  logic          hi_done;
  logic          at_last;

  assign bus.cmd_ready = (state == IDLE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign debug_addr    = {1'b0, addr};
  assign at_last       = (addr == DUMP_LAST6);

  assign op_run  = (cmd_e'(bus.cmd_op) == CMD_RUN);
  assign op_halt = (cmd_e'(bus.cmd_op) == CMD_HALT);
  assign op_step = (cmd_e'(bus.cmd_op) == CMD_STEP);
  assign op_dump = (cmd_e'(bus.cmd_op) == CMD_DUMP);

  // STEP and DUMP only make sense on a halted core
  assign bad_cmd = (op_step || op_dump) && !debug_en;
  assign go_step = op_step && debug_en;
  assign go_dump = op_dump && debug_en;

  debug_step_gen #(
    .STEP_HIGH (STEP_HIGH)
  ) u_step (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && go_step),
    .step    (debug_step),
    .busy    (step_busy),
    .hi_done (hi_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      debug_en     <= 1'b0;
      addr         <= '0;
      wcnt         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_addr  <= '0;
      bus.out_data  <= '0;
      err          <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (1'b1)
              op_run:  debug_en <= 1'b0;
              op_halt: debug_en <= 1'b1;
              bad_cmd: err      <= 1'b1;
              go_step: state    <= STEP_HI;
              go_dump: begin
                addr  <= '0;
                state <= SET_ADDR;
              end
              default: ;
            endcase
          end
        end
        STEP_HI: begin
          if (hi_done)
            state <= STEP_LO;
        end
        STEP_LO: begin
          if (!step_busy)
            state <= IDLE;
        end
        SET_ADDR: begin
          wcnt  <= '0;
          state <= SETTLE_W;
        end
        SETTLE_W: begin
          if (wcnt == WEND) begin
            bus.out_valid <= 1'b1;
            bus.out_addr  <= {1'b0, addr};
            bus.out_data  <= debug_data;
            bus.out_last  <= at_last;
            state        <= EMIT;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            if (at_last) begin
              addr  <= '0;
              state <= IDLE;
            end else begin
              addr  <= addr + 1'b1;
              state <= SET_ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_probe.sv
// Bench for debug_probe: directed control checks plus randomized dumps
// scored against an address-sweep model by an independent monitor.
module tb_debug_probe;

`ifdef DEBUG_PROBE_TESTSIG_EN
  localparam int LAST = 63;
`else
  localparam int LAST = 31;
`endif
  localparam int SH = 4;

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_HALT = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_DUMP = 2'b11;

  typedef struct packed {
    logic [6:0]  a;
    logic [31:0] d;
    logic        l;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        debug_en;
  logic        debug_step;
  logic [6:0]  debug_addr;
  logic [31:0] debug_data;
  logic        err;
  logic [31:0] salt;

  int tests = 0;
  int fails = 0;
  word_t q[$];

  debug_probe_if bus ();

  debug_probe #(
    .STEP_HIGH (SH),
    .SETTLE    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .debug_en   (debug_en),
    .debug_step (debug_step),
    .debug_addr (debug_addr),
    .debug_data (debug_data),
    .err        (err)
  );

  always #5 clk = ~clk;

  // core model: combinational register file contents
  assign debug_data = salt | {25'b0, debug_addr};

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic word_t mk(input int a);
    word_t w;
    w.a = 7'(a);
    w.d = salt | 32'(a);
    w.l = (a == LAST);
    return w;
  endfunction

  // monitor: scores every transfer, checks hold stability on stalls
  initial begin
    word_t prev;
    word_t cur;
    bit held;
    held = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {bus.out_addr, bus.out_data, bus.out_last};
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held && bus.out_valid)
          chk("hold_stable", 64'(cur), 64'(prev));
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL dump_extra got=%0h want=none", cur);
          end else begin
            chk("dump_word", 64'(cur), 64'(q.pop_front()));
          end
          held = 1'b0;
        end else begin
          held = bus.out_valid;
          prev = cur;
        end
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // mode 0: ready high, 1: random ready + stall at 7,
  // 2: RUN pulse mid-dump, 3: reset at address 12
  task automatic run_dump(input logic [31:0] s, input int mode);
    int  n;
    bit  stalled;
    bit  pulsed;
    salt = s;
    for (int a = 0; a <= LAST; a++)
      q.push_back(mk(a));
    bus.out_ready = 1'b1;
    send_cmd(OP_DUMP);
    n = 0;
    stalled = 1'b0;
    pulsed = 1'b0;
    while (!bus.cmd_ready && n < 4000) begin
      if (mode == 1 && !stalled && bus.out_valid && bus.out_addr == 7) begin
        stalled = 1'b1;
        for (int k = 0; k < 5; k++) begin
          bus.out_ready = 1'b0;
          chk("stall_addr", 64'(bus.out_addr), 64'd7);
          chk("stall_data", 64'(bus.out_data), 64'(salt | 32'd7));
          tick();
        end
      end
      if (mode == 2 && !pulsed && n == 20) begin
        pulsed = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_RUN;
        tick();
        bus.cmd_valid = 1'b0;
        chk("run_ignored_en", 64'(debug_en), 64'd1);
      end
      if (mode == 3 && bus.out_valid && bus.out_addr == 12) begin
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mid_addr", 64'(debug_addr), 64'd0);
        chk("rst_mid_en", 64'(debug_en), 64'd0);
        chk("rst_mid_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_mid_left", 64'(q.size()), 64'(LAST - 11));
        q.delete();
        return;
      end
      bus.out_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    chk("dump_done", 64'(bus.cmd_ready), 64'd1);
    chk("dump_all_words", 64'(q.size()), 64'd0);
    chk("dump_addr_zero", 64'(debug_addr), 64'd0);
    chk("dump_en_kept", 64'(debug_en), 64'd1);
    chk("dump_valid_off", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    rst           = 1'b1;
    salt          = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_en", 64'(debug_en), 64'd0);
    chk("rst_step", 64'(debug_step), 64'd0);
    chk("rst_addr", 64'(debug_addr), 64'd0);
    chk("rst_out", {bus.out_valid, bus.out_last, bus.out_addr, bus.out_data},
        64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 64'(bus.cmd_ready), 64'd1);

    send_cmd(OP_STEP);
    chk("step_err", 64'(err), 64'd1);
    chk("step_err_nostep", 64'(debug_step), 64'd0);
    chk("step_err_ready", 64'(bus.cmd_ready), 64'd1);
    tick();
    chk("step_err_pulse", 64'(err), 64'd0);
    chk("step_err_nostep2", 64'(debug_step), 64'd0);

    send_cmd(OP_DUMP);
    chk("dump_err", 64'(err), 64'd1);
    tick();
    chk("dump_err_pulse", 64'(err), 64'd0);
    chk("dump_err_novalid", 64'(bus.out_valid), 64'd0);
    chk("dump_err_addr", 64'(debug_addr), 64'd0);

    send_cmd(OP_HALT);
    chk("halt_en", 64'(debug_en), 64'd1);
    chk("halt_idle", 64'(bus.cmd_ready), 64'd1);
    send_cmd(OP_STEP);
    for (int i = 0; i < 2 * SH; i++) begin
      chk("step_wave", 64'(debug_step), 64'(i < SH));
      chk("step_busy", 64'(bus.cmd_ready), 64'd0);
      chk("step_en", 64'(debug_en), 64'd1);
      tick();
    end
    chk("step_ready_back", 64'(bus.cmd_ready), 64'd1);
    chk("step_low_end", 64'(debug_step), 64'd0);

    run_dump(32'hA500_0000, 0);
    run_dump($urandom & 32'hFFFF_FF80, 1);
    run_dump($urandom & 32'hFFFF_FF80, 2);
    run_dump($urandom & 32'hFFFF_FF80, 3);
    repeat (3) tick();
    chk("no_resume", 64'(bus.out_valid), 64'd0);
    send_cmd(OP_HALT);
    run_dump($urandom & 32'hFFFF_FF80, 1);

    send_cmd(OP_RUN);
    chk("run_en", 64'(debug_en), 64'd0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
